// File: rtl/uart_tx_multi.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_multi
// Purpose  : Parametrised multi-channel UART transmitter. Each channel owns a
//            byte FIFO, a valid/ready write port and a serial tx pin. Frames
//            are start bit, DATA_BITS data bits LSB first, optional parity,
//            then STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
// Ports    : clk       - system clock
//            reset     - synchronous, active-high reset
//            in_data   - channel c byte at [c*DATA_BITS +: DATA_BITS]
//            in_valid  - per-channel write request
//            in_ready  - per-channel FIFO not full (forced low in reset)
//            tx_pin    - per-channel serial output, idle high
//            busy      - per-channel FIFO non-empty or frame in flight
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_multi #(
    parameter int NUM_CH       = 4,
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH*DATA_BITS-1:0]   in_data,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    output logic [NUM_CH-1:0]             tx_pin,
    output logic [NUM_CH-1:0]             busy
);

    localparam int                  c_BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam int                  c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST  = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]          c_DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]          c_STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit                  c_HAS_PARITY = (PARITY != 0);
    localparam logic                c_ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]   r_wr_ptr;
        logic [c_PTR_W-1:0]   r_rd_ptr;
        logic [c_CNT_W-1:0]   r_count;

        state_t               r_state;
        logic [c_BAUD_W-1:0]  r_baud;
        logic [2:0]           r_bit_cnt;
        logic [DATA_BITS-1:0] r_shift;
        logic                 r_par;
        logic                 r_tx;

        logic [DATA_BITS-1:0] w_din;
        logic [DATA_BITS-1:0] w_head;
        logic                 w_head_par;
        logic                 w_full;
        logic                 w_empty;
        logic                 w_push;
        logic                 w_pop;
        logic                 w_baud_end;
        logic                 w_stop_done;

        assign w_din       = in_data[c*DATA_BITS +: DATA_BITS];
        assign w_head      = r_mem[r_rd_ptr];
        assign w_head_par  = (^w_head) ^ c_ODD_PARITY;
        assign w_full      = (r_count == c_FULL);
        assign w_empty     = (r_count == '0);
        // Ready is masked by reset so no write can be taken while flushing.
        assign in_ready[c] = ~w_full & ~reset;
        assign w_push      = in_valid[c] & in_ready[c];
        assign w_baud_end  = (r_baud == c_BAUD_LAST);
        assign w_stop_done = (r_state == ST_STOP) && w_baud_end && (r_bit_cnt == c_STOP_LAST);
        // Pop when idle, or back-to-back at the last stop-bit clock.
        assign w_pop       = ~w_empty & ((r_state == ST_IDLE) | w_stop_done);

        assign tx_pin[c]   = r_tx;
        assign busy[c]     = (r_state != ST_IDLE) | ~w_empty;

        // Storage needs no reset: occupancy is tracked by the pointers/count.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_din;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_baud    <= '0;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_par     <= 1'b0;
                r_tx      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx <= 1'b1;
                        if (w_pop) begin
                            r_state   <= ST_START;
                            r_shift   <= w_head;
                            r_par     <= w_head_par;
                            r_baud    <= '0;
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (w_baud_end) begin
                            r_baud  <= '0;
                            r_state <= ST_DATA;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (w_baud_end) begin
                            r_baud <= '0;
                            if (r_bit_cnt == c_DATA_LAST) begin
                                r_bit_cnt <= '0;
                                if (c_HAS_PARITY) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state <= ST_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (w_baud_end) begin
                            r_baud    <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= ST_STOP;
                            r_tx      <= 1'b1;
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_baud_end) begin
                            r_baud <= '0;
                            if (r_bit_cnt == c_STOP_LAST) begin
                                r_bit_cnt <= '0;
                                if (w_pop) begin
                                    // Next queued byte starts with no idle gap.
                                    r_state <= ST_START;
                                    r_shift <= w_head;
                                    r_par   <= w_head_par;
                                    r_tx    <= 1'b0;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_multi
// Purpose  : Directed self-checking bench for uart_tx_multi. Three instances:
//            dut0 4 channels no parity 1 stop, dut1 even parity 1 stop,
//            dut2 odd parity 2 stops. All use 4 clocks per bit, 8 data bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_multi;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] in_data0;
    logic [3:0]  in_valid0, in_ready0, tx0, busy0;
    logic [7:0]  in_data1, in_data2;
    logic [0:0]  in_valid1, in_ready1, tx1, busy1;
    logic [0:0]  in_valid2, in_ready2, tx2, busy2;

    logic [5:0]  tx_all;
    logic [5:0]  busy_all;
    assign tx_all   = {tx2, tx1, tx0};
    assign busy_all = {busy2, busy1, busy0};

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_bytes [6];

    always #5 clk = ~clk;

    uart_tx_multi #(.NUM_CH(4), .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .tx_pin(tx0), .busy(busy0));

    uart_tx_multi #(.NUM_CH(1), .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx_pin(tx1), .busy(busy1));

    uart_tx_multi #(.NUM_CH(1), .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .tx_pin(tx2), .busy(busy2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks one full frame on tx_all[pin], one comparison per clock.
    // par_bit < 0 means no parity bit in the frame.
    task automatic chk_frame(input int pin, input logic [7:0] data, input int par_bit,
                             input int stops, input string tag);
        for (int k = 0; k < CPB; k++) begin
            chk({tag, "_start"}, 32'(tx_all[pin]), 32'(0));
            step();
        end
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < CPB; k++) begin
                chk({tag, "_data"}, 32'(tx_all[pin]), 32'(data[b]));
                step();
            end
        end
        if (par_bit >= 0) begin
            for (int k = 0; k < CPB; k++) begin
                chk({tag, "_parity"}, 32'(tx_all[pin]), 32'(par_bit));
                step();
            end
        end
        for (int k = 0; k < CPB * stops; k++) begin
            chk({tag, "_stop"}, 32'(tx_all[pin]), 32'(1));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        fifo_bytes[0] = 8'hA1; fifo_bytes[1] = 8'hB2; fifo_bytes[2] = 8'hC3;
        fifo_bytes[3] = 8'hD4; fifo_bytes[4] = 8'hE5; fifo_bytes[5] = 8'hF6;
        reset     = 1'b1;
        in_data0  = '0; in_valid0 = '0;
        in_data1  = '0; in_valid1 = '0;
        in_data2  = '0; in_valid2 = '0;

        // ---- reset state ----
        step(); step(); step();
        chk("rst_ready0", 32'(in_ready0), 32'h0);
        chk("rst_ready1", 32'(in_ready1), 32'h0);
        chk("rst_tx",     32'(tx_all),    32'h3F);
        chk("rst_busy",   32'(busy_all),  32'h00);
        reset = 1'b0;
        #1;
        chk("rel_ready0", 32'(in_ready0), 32'hF);
        chk("rel_ready2", 32'(in_ready2), 32'h1);

        // ---- single frame, ch0, 0x55 ----
        in_data0[7:0] = 8'h55; in_valid0 = 4'b0001;
        step();                                   // accept edge T
        in_valid0 = '0;
        chk("t1_idle_tx",   32'(tx0[0]),   32'(1));
        chk("t1_busy_q",    32'(busy0[0]), 32'(1));
        step();                                   // pop edge T+1
        chk_frame(0, 8'h55, -1, 1, "t1");         // now just after T+41
        chk("t1_busy_end",  32'(busy0[0]), 32'(0));
        chk("t1_tx_end",    32'(tx0[0]),   32'(1));

        // ---- even parity, 0x07 -> parity 1, 44-cycle frame ----
        in_data1 = 8'h07; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        chk_frame(4, 8'h07, 1, 1, "par_even");
        chk("par_even_busy_end", 32'(busy1), 32'(0));

        // ---- odd parity, 2 stop bits, two queued bytes back to back ----
        in_data2 = 8'h07; in_valid2 = 1'b1;
        step();
        in_data2 = 8'h80;
        step();                                   // second byte accepted, first popped
        in_valid2 = 1'b0;
        chk_frame(5, 8'h07, 0, 2, "par_odd_a");
        chk_frame(5, 8'h80, 0, 2, "par_odd_b");
        chk("par_odd_busy_end", 32'(busy2), 32'(0));

        // ---- FIFO fill on ch2 with in_valid held high, A..F ----
        fork
            begin
                int stall;
                in_valid0 = 4'b0100;
                for (int i = 0; i < 5; i++) begin
                    in_data0[23:16] = fifo_bytes[i];
                    step();
                    chk("fifo_ready", 32'(in_ready0[2]), (i < 4) ? 32'(1) : 32'(0));
                end
                in_data0[23:16] = fifo_bytes[5];
                stall = 0;
                while (in_ready0[2] == 1'b0 && stall < 100) begin
                    step();
                    stall++;
                end
                chk("fifo_stall_len", 32'(stall), 32'(37));
                step();                           // F accepted here
                in_valid0 = '0;
            end
            begin
                step(); step();                   // A popped at second edge
                for (int i = 0; i < 6; i++) begin
                    chk_frame(2, fifo_bytes[i], -1, 1, "fifo_frame");
                end
            end
        join
        chk("fifo_busy_end", 32'(busy0[2]), 32'(0));

        // ---- all four channels on one edge ----
        in_data0  = 32'h3CA5FF00;
        in_valid0 = 4'hF;
        step();
        in_valid0 = '0;
        step();
        fork
            chk_frame(0, 8'h00, -1, 1, "all_ch0");
            chk_frame(1, 8'hFF, -1, 1, "all_ch1");
            chk_frame(2, 8'hA5, -1, 1, "all_ch2");
            chk_frame(3, 8'h3C, -1, 1, "all_ch3");
        join
        chk("all_busy_end", 32'(busy0), 32'h0);

        // ---- reset mid-DATA on ch1 with two bytes queued ----
        in_valid0 = 4'b0010;
        in_data0[15:8] = 8'h0F; step();
        in_data0[15:8] = 8'hAA; step();           // 0x0F popped here
        in_data0[15:8] = 8'h55; step();
        in_valid0 = '0;
        step(); step(); step(); step(); step(); step();
        chk("rst_mid_busy", 32'(busy0[1]), 32'(1));
        chk("rst_mid_tx",   32'(tx0[1]),   32'(1)); // data bit 0 of 0x0F
        reset = 1'b1;
        #1;
        chk("rst_mid_ready_low", 32'(in_ready0), 32'h0);
        step();
        chk("rst_mid_tx_after",   32'(tx0[1]),    32'(1));
        chk("rst_mid_busy_after", 32'(busy0[1]),  32'(0));
        chk("rst_mid_ready_hold", 32'(in_ready0), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready_rel",  32'(in_ready0), 32'hF);
        for (int k = 0; k < 60; k++) begin
            step();
            chk("rst_no_residual_tx",   32'(tx_all),   32'h3F);
            chk("rst_no_residual_busy", 32'(busy_all), 32'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
